screen_mode_ctrl: RTL and testbench
===================================

Name: screen_mode_ctrl

Overview:
- Downstream of the start-screen priority mux. Owns the top-level screen state machine: START → FADE → PLAY → OVER.
- Selects the final 8-bit RGB332 pixel from the start-screen, game and game-over layers.
- During FADE, dims the start screen to black over a fixed number of frames.
- Issues a one-cycle game reset pulse when play begins. Output feeds the VGA pixel register.

Parameters:
- FADE_STEP, 8, frames per fade level; fade spans 4 levels, so 4*FADE_STEP frames in total.
- OVER_HOLD, 60, minimum frames the OVER state is held before startKey is honoured.
- BG_RGB, 8'h00, pixel driven when no layer requests drawing.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- startKey  in  1  start button level, already synchronised
- gameOverPulse  in  1  one-cycle pulse from game logic
- startScreenDR  in  1  start-screen layer drawing request
- startScreenRGB  in  8  start-screen layer pixel
- gameDR  in  1  game layer drawing request
- gameRGB  in  8  game layer pixel
- gameOverDR  in  1  game-over text drawing request
- gameOverRGB  in  8  game-over text pixel
- RGBOut  out  8  final pixel, registered
- gameActive  out  1  high while in PLAY, registered
- gameResetPulse  out  1  one-cycle pulse on the FADE→PLAY transition
- screenState  out  2  encoded state: START=0, FADE=1, PLAY=2, OVER=3

Behaviour:
- Reset (async, active-low) → state START, frameCnt=0, fadeLevel=0, keyPrev=0, RGBOut=BG_RGB, gameActive=0, gameResetPulse=0.
- Start detection: startKey rising edge = startKey & ~keyPrev. keyPrev is registered every cycle.
- START:
  - Pixel = startScreenRGB if startScreenDR, else BG_RGB.
  - Rising edge → FADE, frameCnt=0, fadeLevel=0.
- FADE:
  - Pixel is the START pixel dimmed: R[7:5]>>fadeLevel, G[4:2]>>fadeLevel, B[1:0]>>min(fadeLevel,2). Each field stays in its own bit slice, with no carry between fields.
  - On each startOfFrame, frameCnt increments. When frameCnt==FADE_STEP-1: frameCnt=0 and fadeLevel increments.
  - A startOfFrame that arrives while fadeLevel==3 and frameCnt==FADE_STEP-1 → PLAY, with gameResetPulse=1 for exactly that next cycle.
  - startKey edges are ignored.
- PLAY:
  - Pixel = gameRGB if gameDR, else BG_RGB. gameActive=1.
  - gameOverPulse → OVER, frameCnt=0.
  - startKey edges are ignored.
- OVER:
  - Priority: gameOverRGB if gameOverDR, else gameRGB if gameDR, else BG_RGB. gameActive=0.
  - On each startOfFrame, frameCnt increments, saturating at OVER_HOLD.
  - Rising edge with frameCnt==OVER_HOLD → START.
  - Edges before frameCnt reaches OVER_HOLD are dropped, not queued.
- gameOverPulse outside PLAY is ignored.
- Latency: RGBOut = f(inputs, state) registered; 1 clk from layer inputs to RGBOut. A state change affects the pixel selection starting the cycle after the transition edge.
- Simultaneous events:
  - startOfFrame and a transition condition in the same cycle: the transition wins, and frameCnt is cleared, not incremented.
  - gameOverPulse in the same cycle as entering PLAY: ignored, because the state is not yet PLAY.
- Counter widths: frameCnt is wide enough for max(FADE_STEP, OVER_HOLD). fadeLevel is 2 bits and never wraps; it is cleared on FADE entry.
- Reset during any state forces the reset values immediately. A pending gameResetPulse is killed.

Decomposition:
- Shared package screen_pkg holds:
  - the screen_state_t enum (START, FADE, PLAY, OVER) with 2-bit encoding;
  - function dim_rgb332(rgb, level);
  - constants FIELD_R/G/B slice bounds.
- Sub-module edge_detect_rise (clk, resetN, in, pulse) provides startKey edge detection. It is reused for other buttons.
- Everything else lives in one module.

Test Plan:
- Reset, then START with startScreenDR=1, startScreenRGB=8'hFF → RGBOut=8'hFF one cycle later, screenState=0, gameActive=0.
- startKey rising edge, FADE_STEP=2, startScreenRGB=8'hFF held → successive levels give RGBOut 8'hFF, 8'h6D, 8'h24, 8'h00. On the 8th startOfFrame: gameResetPulse high for exactly 1 cycle, screenState=2, gameActive=1.
- In PLAY, gameDR=1, gameRGB=8'h1C → RGBOut=8'h1C. gameDR=0 → BG_RGB. startKey toggles → state unchanged.
- gameOverPulse in PLAY → screenState=3. With gameOverDR=1, gameOverRGB=8'hE0 and gameDR=1 → RGBOut=8'hE0.
- OVER_HOLD=3: startKey edge after 2 frames → stays OVER. Key held high through frame 3 → stays OVER (no edge). Release then press → START.
- resetN asserted mid-FADE (fadeLevel=2) → immediate START, RGBOut=8'h00, no gameResetPulse. gameOverPulse asserted in START → ignored.

Source files
------------

// File: rtl/screen_mode_ctrl_pkg.sv
// Shared types and helpers for the top-level screen controller:
// state encoding, RGB332 field bounds and the per-field fade dimmer.
package screen_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FADE  = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } screen_state_t;

  localparam int unsigned FIELD_R_HI = 7;
  localparam int unsigned FIELD_R_LO = 5;
  localparam int unsigned FIELD_G_HI = 4;
  localparam int unsigned FIELD_G_LO = 2;
  localparam int unsigned FIELD_B_HI = 1;
  localparam int unsigned FIELD_B_LO = 0;

  // Each colour field is shifted inside its own slice; blue has only two
  // bits, so its shift is capped at 2.
  function automatic logic [7:0] dim_rgb332(input logic [7:0] rgb, input logic [1:0] level);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = rgb[FIELD_R_HI:FIELD_R_LO] >> level;
    g = rgb[FIELD_G_HI:FIELD_G_LO] >> level;
    b = rgb[FIELD_B_HI:FIELD_B_LO] >> ((level > 2'd2) ? 2'd2 : level);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/screen_mode_ctrl_edge.sv
// Registered rising-edge detector for synchronised button levels.
module edge_detect_rise (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = in;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/screen_mode_ctrl.sv
// Top-level screen state machine (START -> FADE -> PLAY -> OVER) and
// final RGB332 pixel selection feeding the VGA pixel register.
module screen_mode_ctrl
  import screen_pkg::*;
#(
  parameter int unsigned FADE_STEP = 8,
  parameter int unsigned OVER_HOLD = 60,
  parameter logic [7:0]  BG_RGB    = 8'h00
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       gameOverPulse,
  input  logic       startScreenDR,
  input  logic [7:0] startScreenRGB,
  input  logic       gameDR,
  input  logic [7:0] gameRGB,
  input  logic       gameOverDR,
  input  logic [7:0] gameOverRGB,
  output logic [7:0] RGBOut,
  output logic       gameActive,
  output logic       gameResetPulse,
  output logic [1:0] screenState
);

  localparam int unsigned CNT_MAX = (FADE_STEP > OVER_HOLD) ? FADE_STEP : OVER_HOLD;
  localparam int unsigned FC_W    = $clog2(CNT_MAX + 1);
  localparam logic [FC_W-1:0] FADE_LAST = FC_W'(FADE_STEP - 1);
  localparam logic [FC_W-1:0] HOLD_MAX  = FC_W'(OVER_HOLD);

  screen_state_t   state_q, state_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]      fade_level_q, fade_level_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            active_q, active_d;
  logic            rst_pulse_q, rst_pulse_d;
  logic            key_rise;
  logic [7:0]      start_pix;
  logic [7:0]      game_pix;

  edge_detect_rise u_key_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (startKey),
    .pulse  (key_rise)
  );

  // Transitions take priority over the frame counter update in the same cycle.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    fade_level_d = fade_level_q;
    rst_pulse_d  = 1'b0;
    unique case (state_q)
      START: begin
        if (key_rise) begin
          state_d      = FADE;
          frame_cnt_d  = '0;
          fade_level_d = '0;
        end
      end
      FADE: begin
        if (startOfFrame) begin
          if (frame_cnt_q == FADE_LAST) begin
            frame_cnt_d = '0;
            if (fade_level_q == 2'd3) begin
              state_d     = PLAY;
              rst_pulse_d = 1'b1;
            end else begin
              fade_level_d = fade_level_q + 2'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (gameOverPulse) begin
          state_d     = OVER;
          frame_cnt_d = '0;
        end
      end
      OVER: begin
        if (key_rise && (frame_cnt_q == HOLD_MAX)) begin
          state_d     = START;
          frame_cnt_d = '0;
        end else if (startOfFrame && (frame_cnt_q != HOLD_MAX)) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    start_pix = startScreenDR ? startScreenRGB : BG_RGB;
    game_pix  = gameDR ? gameRGB : BG_RGB;
    rgb_d     = BG_RGB;
    unique case (state_q)
      START:   rgb_d = start_pix;
      FADE:    rgb_d = dim_rgb332(start_pix, fade_level_q);
      PLAY:    rgb_d = game_pix;
      OVER:    rgb_d = gameOverDR ? gameOverRGB : game_pix;
      default: rgb_d = BG_RGB;
    endcase
    active_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= START;
      frame_cnt_q  <= '0;
      fade_level_q <= '0;
      rgb_q        <= BG_RGB;
      active_q     <= 1'b0;
      rst_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      fade_level_q <= fade_level_d;
      rgb_q        <= rgb_d;
      active_q     <= active_d;
      rst_pulse_q  <= rst_pulse_d;
    end
  end

  assign RGBOut         = rgb_q;
  assign gameActive     = active_q;
  assign gameResetPulse = rst_pulse_q;
  assign screenState    = state_q;

endmodule

// File: tb/tb_screen_mode_ctrl.sv
// Scoreboard bench for screen_mode_ctrl with FADE_STEP=2, OVER_HOLD=3.
module tb_screen_mode_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       startKey = 1'b0;
  logic       gameOverPulse = 1'b0;
  logic       startScreenDR = 1'b0;
  logic [7:0] startScreenRGB = 8'h00;
  logic       gameDR = 1'b0;
  logic [7:0] gameRGB = 8'h00;
  logic       gameOverDR = 1'b0;
  logic [7:0] gameOverRGB = 8'h00;
  logic [7:0] RGBOut;
  logic       gameActive;
  logic       gameResetPulse;
  logic [1:0] screenState;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  screen_mode_ctrl #(
    .FADE_STEP (2),
    .OVER_HOLD (3),
    .BG_RGB    (8'h00)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .startKey       (startKey),
    .gameOverPulse  (gameOverPulse),
    .startScreenDR  (startScreenDR),
    .startScreenRGB (startScreenRGB),
    .gameDR         (gameDR),
    .gameRGB        (gameRGB),
    .gameOverDR     (gameOverDR),
    .gameOverRGB    (gameOverRGB),
    .RGBOut         (RGBOut),
    .gameActive     (gameActive),
    .gameResetPulse (gameResetPulse),
    .screenState    (screenState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (RGBOut !== 8'h00) begin n_err++; $display("FAIL reset_rgb: got %h want 00", RGBOut); end
    n_cmp++;
    if (screenState !== 2'd0 || gameActive !== 1'b0 || gameResetPulse !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: state=%0d active=%b pulse=%b want 0/0/0", screenState, gameActive, gameResetPulse);
    end
    @(negedge clk);
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_start_pixel();
    startScreenDR = 1'b1; startScreenRGB = 8'hFF;
    exp_q.push_back(8'hFF);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL start_pix: got %h want %h", RGBOut, exp_v); end
    startScreenDR = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL start_bg: got %h want %h", RGBOut, exp_v); end
    n_cmp++;
    if (screenState !== 2'd0 || gameActive !== 1'b0) begin
      n_err++; $display("FAIL start_state: state=%0d active=%b want 0/0", screenState, gameActive);
    end
    startScreenDR = 1'b1;
  endtask

  task automatic test_fade();
    logic [7:0] lvl_pix [4];
    lvl_pix[0] = 8'hFF; lvl_pix[1] = 8'h6D; lvl_pix[2] = 8'h24; lvl_pix[3] = 8'h00;
    startScreenDR = 1'b1; startScreenRGB = 8'hFF; startKey = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    startKey = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL fade_entry_pix: got %h want %h", RGBOut, exp_v); end
    n_cmp++;
    if (screenState !== 2'd1) begin n_err++; $display("FAIL fade_entry_state: got %0d want 1", screenState); end
    for (int f = 0; f < 8; f++) begin
      exp_q.push_back(lvl_pix[f/2]);
      tick();
      exp_v = exp_q.pop_front(); n_cmp++;
      if (RGBOut !== exp_v) begin n_err++; $display("FAIL fade_idle[%0d]: got %h want %h", f, RGBOut, exp_v); end
      startOfFrame = 1'b1;
      if (f == 3) startKey = 1'b1;
      if (f == 7) gameOverPulse = 1'b1;
      exp_q.push_back(lvl_pix[f/2]);
      tick();
      startOfFrame = 1'b0; startKey = 1'b0; gameOverPulse = 1'b0;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (RGBOut !== exp_v) begin n_err++; $display("FAIL fade_sof[%0d]: got %h want %h", f, RGBOut, exp_v); end
      if (f < 7) begin
        n_cmp++;
        if (screenState !== 2'd1 || gameResetPulse !== 1'b0) begin
          n_err++; $display("FAIL fade_hold[%0d]: state=%0d pulse=%b want 1/0", f, screenState, gameResetPulse);
        end
      end
    end
    n_cmp++;
    if (gameResetPulse !== 1'b1 || screenState !== 2'd2 || gameActive !== 1'b1) begin
      n_err++; $display("FAIL play_entry: pulse=%b state=%0d active=%b want 1/2/1", gameResetPulse, screenState, gameActive);
    end
    startScreenDR = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL play_first_pix: got %h want %h", RGBOut, exp_v); end
    n_cmp++;
    if (gameResetPulse !== 1'b0 || screenState !== 2'd2) begin
      n_err++; $display("FAIL pulse_width: pulse=%b state=%0d want 0/2", gameResetPulse, screenState);
    end
  endtask

  task automatic test_play();
    gameDR = 1'b1; gameRGB = 8'h1C;
    exp_q.push_back(8'h1C);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL play_pix: got %h want %h", RGBOut, exp_v); end
    gameDR = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL play_bg: got %h want %h", RGBOut, exp_v); end
    startKey = 1'b1; tick();
    startKey = 1'b0; tick();
    startKey = 1'b1; tick();
    startKey = 1'b0; tick();
    n_cmp++;
    if (screenState !== 2'd2 || gameActive !== 1'b1) begin
      n_err++; $display("FAIL play_key_ignored: state=%0d active=%b want 2/1", screenState, gameActive);
    end
  endtask

  task automatic test_game_over();
    gameDR = 1'b1; gameRGB = 8'h1C; gameOverDR = 1'b1; gameOverRGB = 8'hE0; gameOverPulse = 1'b1;
    exp_q.push_back(8'h1C);
    tick();
    gameOverPulse = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL over_edge_pix: got %h want %h", RGBOut, exp_v); end
    n_cmp++;
    if (screenState !== 2'd3 || gameActive !== 1'b0) begin
      n_err++; $display("FAIL over_entry: state=%0d active=%b want 3/0", screenState, gameActive);
    end
    exp_q.push_back(8'hE0);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL over_text: got %h want %h", RGBOut, exp_v); end
    gameOverDR = 1'b0;
    exp_q.push_back(8'h1C);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL over_game: got %h want %h", RGBOut, exp_v); end
    gameDR = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL over_bg: got %h want %h", RGBOut, exp_v); end
  endtask

  task automatic test_over_hold();
    for (int i = 0; i < 2; i++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
    startKey = 1'b1; tick(); tick();
    n_cmp++;
    if (screenState !== 2'd3) begin n_err++; $display("FAIL over_early_key: got %0d want 3", screenState); end
    startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; tick(); tick();
    n_cmp++;
    if (screenState !== 2'd3) begin n_err++; $display("FAIL over_held_key: got %0d want 3", screenState); end
    startKey = 1'b0; tick();
    startKey = 1'b1; tick();
    n_cmp++;
    if (screenState !== 2'd0 || gameActive !== 1'b0) begin
      n_err++; $display("FAIL over_to_start: state=%0d active=%b want 0/0", screenState, gameActive);
    end
    startScreenDR = 1'b1; startScreenRGB = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL restart_pix: got %h want %h", RGBOut, exp_v); end
    startKey = 1'b0; tick();
    n_cmp++;
    if (screenState !== 2'd0) begin n_err++; $display("FAIL restart_hold: got %0d want 0", screenState); end
  endtask

  task automatic test_reset_mid_fade();
    startScreenDR = 1'b1; startScreenRGB = 8'hFF; startKey = 1'b1;
    tick();
    startKey = 1'b0;
    for (int i = 0; i < 4; i++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
    exp_q.push_back(8'h24);
    tick();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (RGBOut !== exp_v) begin n_err++; $display("FAIL fade_lvl2: got %h want %h", RGBOut, exp_v); end
    #2 resetN = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++;
    if (RGBOut !== 8'h00 || screenState !== 2'd0 || gameResetPulse !== 1'b0 || gameActive !== 1'b0) begin
      n_err++; $display("FAIL midfade_reset: rgb=%h state=%0d pulse=%b active=%b want 00/0/0/0",
                        RGBOut, screenState, gameResetPulse, gameActive);
    end
    tick();
    resetN = 1'b1;
    gameOverPulse = 1'b1; tick();
    gameOverPulse = 1'b0; tick();
    n_cmp++;
    if (screenState !== 2'd0 || gameActive !== 1'b0) begin
      n_err++; $display("FAIL start_gameover_ignored: state=%0d active=%b want 0/0", screenState, gameActive);
    end
  endtask

  task automatic test_back_to_back();
    startKey = 1'b1; tick();
    startKey = 1'b0;
    for (int i = 0; i < 8; i++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0;
    end
    n_cmp++;
    if (gameResetPulse !== 1'b1 || screenState !== 2'd2) begin
      n_err++; $display("FAIL b2b_play: pulse=%b state=%0d want 1/2", gameResetPulse, screenState);
    end
    #2 resetN = 1'b0;
    #1;
    n_cmp++;
    if (gameResetPulse !== 1'b0 || screenState !== 2'd0 || gameActive !== 1'b0) begin
      n_err++; $display("FAIL pulse_killed: pulse=%b state=%0d active=%b want 0/0/0", gameResetPulse, screenState, gameActive);
    end
    tick();
    resetN = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_pixel();
    test_fade();
    test_play();
    test_game_over();
    test_over_hold();
    test_reset_mid_fade();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
